// File: rtl/mem_stage_if.sv
// Bus between the EXE/MEM buffer, the MEM stage and the MEM/WB buffer.
// The master side issues instructions and the slave side is the MEM stage itself.
interface mem_stage_if #(
  parameter int DW  = 32,
  parameter int RFW = 5
);
  logic           valid_in;
  logic           is_load;
  logic           is_store;
  logic           reg_we_in;
  logic [2:0]     funct3;
  logic [DW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [RFW-1:0] rd_in;

  logic           stall;
  logic           valid_out;
  logic           reg_we_out;
  logic [RFW-1:0] rd_out;
  logic [DW-1:0]  result;
  logic           misalign;

  modport master (
    output valid_in, is_load, is_store, reg_we_in, funct3, addr, wdata, rd_in,
    input  stall, valid_out, reg_we_out, rd_out, result, misalign
  );

  modport slave (
    input  valid_in, is_load, is_store, reg_we_in, funct3, addr, wdata, rd_in,
    output stall, valid_out, reg_we_out, rd_out, result, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-organised synchronous data RAM with byte/half/word
// loads and stores. Loads take two cycles and stall upstream for one.
module mem_stage #(
  parameter int DW  = 32,
  parameter int RFW = 5,
  parameter int DMW = 6
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);

  localparam int WORDS = 1 << DMW;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic           reg_we_q, reg_we_d;
  logic           mis_q, mis_d;
  logic [RFW-1:0] rd_q, rd_d;
  logic [DW-1:0]  result_q, result_d;

  logic [1:0]     off_q;
  logic [2:0]     f3_q;
  logic [RFW-1:0] ld_rd_q;
  logic           ld_mis_q;

  logic [DW-1:0]  mem [WORDS];
  logic [DW-1:0]  rdata_q;

  logic           is_byte, is_half, access_mis;
  logic           accept, load_acc, store_we;
  logic [DMW-1:0] word_idx;
  logic [3:0]     byte_en;
  logic [DW-1:0]  store_data;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [DW-1:0]  ld_data;
  logic           unused_addr;

  assign is_byte    = (bus.funct3[1:0] == 2'b00);
  assign is_half    = (bus.funct3[1:0] == 2'b01);
  assign access_mis = (is_half & bus.addr[0]) |
                      (~is_byte & ~is_half & (bus.addr[1:0] != 2'b00));

  // A load held upstream during LOAD_WAIT is never re-accepted because only IDLE accepts.
  assign accept   = ~rst & (state_q == IDLE) & bus.valid_in;
  assign load_acc = accept & bus.is_load;
  assign store_we = accept & bus.is_store & ~bus.is_load & ~access_mis;
  assign word_idx = bus.addr[DMW+1:2];

  assign unused_addr = ^bus.addr[DW-1:DMW+2];

  always_comb begin
    byte_en    = 4'b1111;
    store_data = bus.wdata;
    if (is_byte) begin
      byte_en    = 4'b0001 << bus.addr[1:0];
      store_data = {4{bus.wdata[7:0]}};
    end else if (is_half) begin
      byte_en    = bus.addr[1] ? 4'b1100 : 4'b0011;
      store_data = {2{bus.wdata[15:0]}};
    end
  end

  // RAM has no reset; stores commit and loads are read on the accepting edge.
  always_ff @(posedge clk) begin
    if (store_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
    if (load_acc) begin
      rdata_q <= mem[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q    <= '0;
      f3_q     <= '0;
      ld_rd_q  <= '0;
      ld_mis_q <= 1'b0;
    end else if (load_acc) begin
      off_q    <= bus.addr[1:0];
      f3_q     <= bus.funct3;
      ld_rd_q  <= bus.rd_in;
      ld_mis_q <= access_mis;
    end
  end

  assign ld_byte = rdata_q[8*off_q +: 8];
  assign ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      mis_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      mis_q    <= mis_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    reg_we_d = 1'b0;
    mis_d    = 1'b0;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          if (bus.is_load) begin
            state_d = LOAD_WAIT;
          end else if (bus.is_store) begin
            valid_d  = 1'b1;
            rd_d     = bus.rd_in;
            result_d = '0;
            mis_d    = access_mis;
          end else begin
            valid_d  = 1'b1;
            rd_d     = bus.rd_in;
            result_d = bus.addr;
            reg_we_d = bus.reg_we_in;
          end
        end
      end
      LOAD_WAIT: begin
        state_d = IDLE;
        valid_d = 1'b1;
        rd_d    = ld_rd_q;
        if (ld_mis_q) begin
          result_d = '0;
          mis_d    = 1'b1;
        end else begin
          result_d = ld_data;
          reg_we_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stall      = load_acc;
  assign bus.valid_out  = valid_q;
  assign bus.reg_we_out = reg_we_q;
  assign bus.misalign   = mis_q;
  assign bus.rd_out     = rd_q;
  assign bus.result     = result_q;

endmodule
